min_n_scan: RTL and testbench
=============================

# min_n_scan

Parametrised N-channel extremum finder, the successor to the three-channel 8-bit minimum unit. It starts N converters with a shared `soc` and waits for every `eoc`. It then captures all N samples and scans them serially through one comparator to find the minimum or maximum. The result goes out over the `dav_`/`rfd` handshake to the downstream consumer.

## Interface
- `N`, default 3: number of input channels, ≥ 1.
- `W`, default 8: sample width in bits, unsigned, ≥ 2.
- `IW`, default `$clog2(N)` (min 1): channel index width.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  **synchronous, active-high reset**, sampled on `clock`.
- `eoc`  in  N  per-channel end-of-conversion.
- `x`  in  N·W  packed samples; channel i at bits `[i*W +: W]`.
- `mode`  in  1  0 = minimum, 1 = maximum; sampled at capture.
- `rfd`  in  1  consumer ready-for-data.
- `soc`  out  1  start-of-conversion to all channels.
- `dav_`  out  1  data valid, active low.
- `ext`  out  W  result value.
- `idx`  out  IW  winning channel (only with `MIN_N_SCAN_IDX_EN`).

## Operation
States: S_START, S_WAIT, S_SCAN, S_OUT, S_REL.
- **S_START**
  - `soc`=1.
  - Go to S_WAIT when all `eoc`==0; else stay.
- **S_WAIT**
  - `soc`=0.
  - When all `eoc`==1: capture `x` into sample regs X[0..N-1] and `mode` into MODE.
  - Load accumulator ACC←X[0] (from the live `x`), AIDX←0, scan counter CNT←1.
  - Go to S_SCAN; if N==1, go straight to S_OUT.
- **S_SCAN**, one channel per cycle:
  - Compare X[CNT] against ACC.
  - Replace ACC/AIDX when X[CNT]<ACC (MODE=0) or X[CNT]>ACC (MODE=1). Strict compare, so ties keep the lower index.
  - CNT++. After CNT==N-1 is processed, load `ext`←final ACC, `idx`←final AIDX, `dav_`←0, go to S_OUT.
- **S_OUT**
  - Hold `ext`/`idx` stable, `dav_`=0.
  - Go to S_REL when `rfd`==0.
- **S_REL**
  - `dav_`=1.
  - Go to S_START when `rfd`==1.
- Arithmetic: unsigned W-bit magnitude compare, derived from the borrow-out of a W-bit subtractor. No wrap or overflow cases exist.
- Partial `eoc` patterns (mixed 0/1) keep the FSM in S_START or S_WAIT respectively.
- `x` is ignored outside the capture edge; changes during S_SCAN have no effect.
- Reset values: `soc`=0, `dav_`=1, `ext`=0, `idx`=0, state S_START, CNT=0.
- Reset mid-operation (any state) has priority over all transitions. It aborts the scan or handshake and applies the reset values on that edge; no partial result is ever presented.

## Timing
- All outputs are registered; none is combinational from inputs.
- Capture edge = edge k where all `eoc`==1 in S_WAIT.
- `dav_` falls at edge k+N-1 for N ≥ 2, and at k+1 for N==1.
- `ext`/`idx` are valid at that same edge and stable until `dav_` rises.
- `soc` re-asserts on the edge after `rfd` is seen high in S_REL.
- `rfd` and `eoc` are synchronous to `clock`; this block does not synchronise them.

## Configuration
- `MIN_N_SCAN_IDX_EN` defined:
  - `idx` port exists.
  - AIDX register is tracked and loaded into `idx` alongside `ext`.
- Not defined:
  - No `idx` port and no AIDX logic.
  - `ext` behaviour is identical.

## Structure
- Shared package `min_n_scan_pkg`:
  - state enum (S_START…S_REL) and its 3-bit encoding.
  - `MODE_MIN`/`MODE_MAX` constants.
  - default `N`/`W`.
- One sub-module, `cmp_sel`: combinational W-bit unsigned compare (borrow-based) plus mode select. It outputs a `take` bit meaning "replace accumulator".
- The top contains the FSM, the X[] bank, ACC/AIDX/CNT and the output registers.

## Test plan
- N=3, W=8, mode=0, x={0x40,0x12,0x7F}, full eoc and rfd cycle → `ext`=0x12, `idx`=1, `dav_` low 2 cycles after capture.
- N=4, mode=1, x={0x05,0xF0,0xF0,0x01} → `ext`=0xF0, `idx`=1 (tie keeps lower index).
- N=1, x=0xAB → `ext`=0xAB, `idx`=0, `dav_` low 1 cycle after capture.
- N=3, eoc=3'b011 held 10 cycles in S_WAIT → no capture, `soc`=0, `dav_`=1; raise eoc[2] → capture proceeds normally.
- Assert `reset` for one cycle during S_SCAN (N=8), then run x=all 0xFF except ch5=0x00, mode=0 → first result never appears; after restart `ext`=0x00, `idx`=5.
- Hold `rfd`=1 in S_OUT for 20 cycles → `ext`/`dav_` stable. Drop then raise `rfd` → `dav_` rises, then `soc` re-asserts one cycle after `rfd` is seen high.

Source files
------------

// File: rtl/min_n_scan_pkg.sv
// Shared types and defaults for the min_n_scan extremum finder.
package min_n_scan_pkg;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_WAIT  = 3'd1,
        S_SCAN  = 3'd2,
        S_OUT   = 3'd3,
        S_REL   = 3'd4
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    localparam int DEF_N = 3;
    localparam int DEF_W = 8;

endpackage

// File: rtl/min_n_scan_cmp_sel.sv
// Unsigned compare built on a single subtractor's borrow, plus min/max select.
// take=1 means the candidate should replace the accumulator (strict compare).
module cmp_sel
    import min_n_scan_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] cand,
    input  logic [W-1:0] acc,
    input  logic         mode,
    output logic         take
);

    logic [W:0] diff;
    logic       cand_lt;
    logic       cand_gt;

    assign diff    = {1'b0, cand} - {1'b0, acc};
    assign cand_lt = diff[W];
    // No borrow and a non-zero difference means strictly greater.
    assign cand_gt = ~diff[W] & (|diff[W-1:0]);
    assign take    = (mode == MODE_MAX) ? cand_gt : cand_lt;

endmodule

// File: rtl/min_n_scan.sv
// N-channel min/max finder: soc/eoc conversion handshake, serial scan, dav_/rfd output.
// Define MIN_N_SCAN_IDX_EN to add the idx port reporting the winning channel.
module min_n_scan
    import min_n_scan_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   eoc,
    input  logic [N*W-1:0] x,
    input  logic           mode,
    input  logic           rfd,
    output logic           soc,
    output logic           dav_,
    output logic [W-1:0]   ext
`ifdef MIN_N_SCAN_IDX_EN
    ,
    output logic [IW-1:0]  idx
`endif
);

    state_t        state_reg;
    state_t        state_next;
    logic [W-1:0]  x_chan [N];
    logic [W-1:0]  x_bank_reg [N];
    logic [W-1:0]  acc_reg;
    logic [IW-1:0] cnt_reg;
    logic          mode_reg;
    logic          soc_reg;
    logic          dav_reg;
    logic [W-1:0]  ext_reg;
    logic [W-1:0]  cand;
    logic          take;
    logic          capture;
    logic          last_cnt;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign x_chan[gi] = x[gi*W +: W];
    end

    assign capture  = (state_reg == S_WAIT) && (&eoc);
    assign last_cnt = (cnt_reg == IW'(N - 1));

    always_comb begin
        cand = x_bank_reg[0];
        for (int i = 1; i < N; i++) begin
            if (cnt_reg == IW'(i)) begin
                cand = x_bank_reg[i];
            end
        end
    end

    cmp_sel #(.W(W)) u_cmp_sel (
        .cand (cand),
        .acc  (acc_reg),
        .mode (mode_reg),
        .take (take)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_START: if (~|eoc) state_next = S_WAIT;
            S_WAIT:  if (&eoc) state_next = (N == 1) ? S_OUT : S_SCAN;
            S_SCAN:  if (last_cnt) state_next = S_OUT;
            // dav_reg still high means a single-channel result has not been presented yet.
            S_OUT:   if (!dav_reg && !rfd) state_next = S_REL;
            S_REL:   if (rfd) state_next = S_START;
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                x_bank_reg[i] <= x_chan[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_START;
            soc_reg   <= 1'b0;
            dav_reg   <= 1'b1;
            ext_reg   <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mode_reg  <= MODE_MIN;
        end else begin
            state_reg <= state_next;
            soc_reg   <= (state_next == S_START);
            if (capture) begin
                mode_reg <= mode;
                acc_reg  <= x_chan[0];
                cnt_reg  <= IW'(1);
            end else if (state_reg == S_SCAN) begin
                cnt_reg <= cnt_reg + IW'(1);
                if (take) begin
                    acc_reg <= cand;
                end
                if (last_cnt) begin
                    ext_reg <= take ? cand : acc_reg;
                    dav_reg <= 1'b0;
                end
            end
            if (state_reg == S_OUT && dav_reg) begin
                ext_reg <= acc_reg;
                dav_reg <= 1'b0;
            end
            if (state_reg == S_OUT && state_next == S_REL) begin
                dav_reg <= 1'b1;
            end
        end
    end

`ifdef MIN_N_SCAN_IDX_EN
    logic [IW-1:0] aidx_reg;
    logic [IW-1:0] idx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            aidx_reg <= '0;
            idx_reg  <= '0;
        end else begin
            if (capture) begin
                aidx_reg <= '0;
            end else if (state_reg == S_SCAN) begin
                if (take) begin
                    aidx_reg <= cnt_reg;
                end
                if (last_cnt) begin
                    idx_reg <= take ? cnt_reg : aidx_reg;
                end
            end
            if (state_reg == S_OUT && dav_reg) begin
                idx_reg <= aidx_reg;
            end
        end
    end

    assign idx = idx_reg;
`endif

    assign soc  = soc_reg;
    assign dav_ = dav_reg;
    assign ext  = ext_reg;

endmodule

// File: tb/tb_min_n_scan.sv
// Bench for min_n_scan: four instances (N=1,3,4,8) run directed and random
// transactions in parallel against a value-then-first-index reference model.
module tb_min_n_scan;

    localparam int W = 8;
    localparam int NINST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: find the extreme value, then the lowest channel holding it.
    function automatic logic [15:0] ref_extreme(input logic [63:0] xv, input int n, input logic md);
        int best;
        int bi;
        int v;
        best = md ? -1 : 256;
        for (int i = 0; i < n; i++) begin
            v = int'(xv[i*8 +: 8]);
            if (md ? (v > best) : (v < best)) best = v;
        end
        bi = -1;
        for (int i = 0; i < n; i++) begin
            v = int'(xv[i*8 +: 8]);
            if (bi < 0 && v == best) bi = i;
        end
        return {8'(bi), 8'(best)};
    endfunction

    for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
        localparam int NN  = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 8;
        localparam int IWW = (NN > 1) ? $clog2(NN) : 1;
        localparam logic [63:0] DIR_X = (NN == 1) ? 64'hAB :
                                        (NN == 3) ? 64'h7F1240 :
                                        (NN == 4) ? 64'h01F0F005 : 64'hFFFF00FFFFFFFFFF;
        localparam logic       DIR_MODE = (NN == 4);
        localparam logic [7:0] DIR_EXT  = (NN == 1) ? 8'hAB : (NN == 3) ? 8'h12 :
                                          (NN == 4) ? 8'hF0 : 8'h00;
        localparam int DIR_IDX = (NN == 1) ? 0 : (NN == 3) ? 1 : (NN == 4) ? 1 : 5;
        localparam int PART    = (NN == 3) ? 10 : 0;
        localparam int ABORT   = (NN == 8) ? 3 : 0;

        logic            reset;
        logic [NN-1:0]   eoc;
        logic [NN*W-1:0] x;
        logic            mode;
        logic            rfd;
        logic            soc;
        logic            dav_;
        logic [W-1:0]    ext;
`ifdef MIN_N_SCAN_IDX_EN
        logic [IWW-1:0]  idx;
`endif
        logic            model_valid = 1'b0;
        logic            armed = 1'b0;
        logic            fin = 1'b0;
        logic [7:0]      exp_ext = '0;
        int              exp_idx = 0;

        min_n_scan #(.N(NN), .W(W)) dut (
            .clock (clk),
            .reset (reset),
            .eoc   (eoc),
            .x     (x),
            .mode  (mode),
            .rfd   (rfd),
            .soc   (soc),
            .dav_  (dav_),
            .ext   (ext)
`ifdef MIN_N_SCAN_IDX_EN
            ,
            .idx   (idx)
`endif
        );

        task automatic c(input string nm, input logic [31:0] act, input logic [31:0] exp);
            chk($sformatf("N%0d %s", NN, nm), act, exp);
        endtask

        // Whenever a result is presented it must match the model.
        always @(negedge clk) begin
            if (armed && dav_ === 1'b0) begin
                if (!model_valid) begin
                    c("stray_dav", 32'(dav_), 32'd1);
                end else begin
                    c("ext", 32'(ext), 32'(exp_ext));
`ifdef MIN_N_SCAN_IDX_EN
                    c("idx", 32'(idx), 32'(exp_idx));
`endif
                end
            end
        end

        task automatic txn(input logic [63:0] xv, input logic md, input int part,
                           input int hold, input int abort_after, input bit use_lit);
            logic [15:0] r;
            int j;
            r = ref_extreme(xv, NN, md);
            if (use_lit) begin
                c("model_ext", 32'(r[7:0]), 32'(DIR_EXT));
                c("model_idx", 32'(r[15:8]), 32'(DIR_IDX));
            end
            j = 0;
            while (soc !== 1'b1 && j < 30) begin
                @(negedge clk);
                j++;
            end
            c("soc_idle", 32'(soc), 32'd1);
            @(negedge clk);
            eoc = '0;
            @(posedge clk); #1;
            c("soc_drop", 32'(soc), 32'd0);
            for (int k = 0; k < part; k++) begin
                @(negedge clk);
                eoc = '1;
                eoc[NN-1] = 1'b0;
                @(posedge clk); #1;
                c("partial_soc", 32'(soc), 32'd0);
                c("partial_dav", 32'(dav_), 32'd1);
            end
            @(negedge clk);
            x = xv[NN*W-1:0];
            mode = md;
            eoc = '1;
            @(posedge clk); #1;
            // Inputs after the capture edge must not matter.
            for (int i = 0; i < NN; i++) x[i*W +: W] = 8'($urandom);
            mode = ~md;
            if (abort_after > 0) begin
                repeat (abort_after) @(negedge clk);
                reset = 1'b1;
                @(posedge clk); #1;
                c("abort_soc", 32'(soc), 32'd0);
                c("abort_dav", 32'(dav_), 32'd1);
                c("abort_ext", 32'(ext), 32'd0);
`ifdef MIN_N_SCAN_IDX_EN
                c("abort_idx", 32'(idx), 32'd0);
`endif
                @(negedge clk);
                reset = 1'b0;
            end else begin
                exp_ext = r[7:0];
                exp_idx = int'(r[15:8]);
                model_valid = 1'b1;
                j = 0;
                do begin
                    @(posedge clk); #1;
                    j++;
                end while (dav_ !== 1'b0 && j < 40);
                c("latency", 32'(j), (NN == 1) ? 32'd1 : 32'(NN - 1));
                repeat (hold) @(negedge clk);
                c("hold_dav", 32'(dav_), 32'd0);
                c("hold_ext", 32'(ext), 32'(exp_ext));
                @(negedge clk);
                rfd = 1'b0;
                @(posedge clk); #1;
                c("dav_rise", 32'(dav_), 32'd1);
                c("soc_in_rel", 32'(soc), 32'd0);
                model_valid = 1'b0;
                @(negedge clk);
                rfd = 1'b1;
                @(posedge clk); #1;
                c("soc_reassert", 32'(soc), 32'd1);
            end
        endtask

        initial begin
            logic [63:0] rv;
            int lows;
            reset = 1'b1;
            eoc   = '1;
            x     = '0;
            mode  = 1'b0;
            rfd   = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            c("rst_soc", 32'(soc), 32'd0);
            c("rst_dav", 32'(dav_), 32'd1);
            c("rst_ext", 32'(ext), 32'd0);
`ifdef MIN_N_SCAN_IDX_EN
            c("rst_idx", 32'(idx), 32'd0);
`endif
            @(negedge clk);
            reset = 1'b0;
            armed = 1'b1;

            txn(DIR_X, DIR_MODE, PART, 20, 0, 1'b1);
            for (int t = 0; t < 6; t++) begin
                rv = '0;
                for (int i = 0; i < NN; i++)
                    rv[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
                txn(rv, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3), 0, 1'b0);
            end
            txn(64'h3333333333333333, 1'b0, 0, 1, 0, 1'b0);
            txn(64'h3333333333333333, 1'b1, 0, 1, 0, 1'b0);

            rv = '0;
            for (int i = 0; i < NN; i++) rv[i*8 +: 8] = 8'($urandom);
            txn(rv, 1'b0, 0, 2, ABORT, 1'b0);
            lows = 0;
            repeat (15) begin
                @(negedge clk);
                if (dav_ === 1'b0) lows++;
            end
            c("no_partial_result", 32'(lows), 32'd0);
            txn(DIR_X, DIR_MODE, 0, 20, 0, 1'b1);
            fin = 1'b1;
        end
    end

    initial begin
        int cyc;
        logic all_done;
        cyc = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            all_done = g_inst[0].fin & g_inst[1].fin & g_inst[2].fin & g_inst[3].fin;
        end
        chk("all_instances_done", 32'(all_done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
